// File: rtl/chip8_rom_loader.sv
// chip8_rom_loader
// Streams a Chip-8 program image into CPU memory through port A starting at
// BASE_ADDR, holding the CPU in halt until the image is in place.
// Optional read-back checksum verify: define CHIP8_LOADER_VERIFY_EN.
//
// Stream handshake: a byte transfers on a rising clk edge when s_valid and
// s_ready are both high; s_ready is high exactly while the FSM is in LOAD,
// and s_data/s_last are sampled on that same edge.
module chip8_rom_loader #(
    parameter logic [11:0] BASE_ADDR     = 12'h200,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        mem_en,
    output logic        mem_write,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        cpu_halt,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [11:0] byte_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FLUSH  = 3'd2,
`ifdef CHIP8_LOADER_VERIFY_EN
        ST_VERIFY = 3'd3,
`endif
        ST_DONE   = 3'd4
    } state_t;

    // Current FSM state, kept as a named signal so checkers can bind to it.
    state_t      state;
    state_t      state_next;

    logic [11:0] ptr;
    logic        xfer;
    logic        at_top;

    assign xfer   = s_valid && s_ready;
    assign at_top = (ptr == 12'hFFF);

`ifdef CHIP8_LOADER_VERIFY_EN
    logic [7:0]  checksum;
    logic [7:0]  rd_sum;
    logic [11:0] rd_idx;
    logic        rd_pending;
    logic        rd_issue_done;
    logic        verify_end;

    // All reads issued, none on the bus and no data still in flight.
    assign rd_issue_done = (rd_idx == byte_count);
    assign verify_end    = rd_issue_done && !(mem_en && !mem_write) && !rd_pending;
`else
    // Read data is only consumed by the verify pass.
    logic unused_dout;
    assign unused_dout = ^mem_dout;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
            ST_LOAD:          if (xfer && (s_last || at_top)) state_next = ST_FLUSH;
`ifdef CHIP8_LOADER_VERIFY_EN
            ST_FLUSH:         state_next = ST_VERIFY;
            ST_VERIFY:        if (verify_end) state_next = ST_DONE;
`else
            ST_FLUSH:         state_next = ST_DONE;
`endif
            default:          state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state; IDLE is only reachable from reset.
    always_comb begin
        s_ready  = (state == ST_LOAD);
        done     = (state == ST_DONE);
        busy     = (state != ST_IDLE) && (state != ST_DONE);
        cpu_halt = (state == ST_IDLE) ? HOLD_AT_RESET : (state != ST_DONE);
    end

    // Registered memory port, byte counter, error flag and checksum path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_din    <= 8'h00;
            byte_count <= 12'd0;
            error      <= 1'b0;
            ptr        <= BASE_ADDR;
`ifdef CHIP8_LOADER_VERIFY_EN
            checksum   <= 8'h00;
            rd_sum     <= 8'h00;
            rd_idx     <= 12'd0;
            rd_pending <= 1'b0;
`endif
        end else begin
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
`ifdef CHIP8_LOADER_VERIFY_EN
            // Read data returns the cycle after the read strobe.
            rd_pending <= mem_en && !mem_write;
            if (rd_pending) rd_sum <= rd_sum + mem_dout;
`endif
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        error      <= 1'b0;
                        byte_count <= 12'd0;
                        ptr        <= BASE_ADDR;
`ifdef CHIP8_LOADER_VERIFY_EN
                        checksum   <= 8'h00;
`endif
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        mem_en     <= 1'b1;
                        mem_write  <= 1'b1;
                        mem_addr   <= ptr;
                        mem_din    <= s_data;
                        byte_count <= byte_count + 12'd1;
`ifdef CHIP8_LOADER_VERIFY_EN
                        checksum   <= checksum + s_data;
`endif
                        // Pointer saturates at the top of memory, never wraps.
                        if (!at_top) ptr <= ptr + 12'd1;
                        if (at_top && !s_last) error <= 1'b1;
                    end
                end
`ifdef CHIP8_LOADER_VERIFY_EN
                ST_FLUSH: begin
                    rd_idx <= 12'd0;
                    rd_sum <= 8'h00;
                end
                ST_VERIFY: begin
                    if (!rd_issue_done) begin
                        mem_en    <= 1'b1;
                        mem_write <= 1'b0;
                        mem_addr  <= BASE_ADDR + rd_idx;
                        rd_idx    <= rd_idx + 12'd1;
                    end
                    if (verify_end && (rd_sum != checksum)) error <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_rom_loader.sv
// Testbench for chip8_rom_loader: random image streams checked by a
// scoreboard of expected port-A writes (and verify reads when enabled).
module tb_chip8_rom_loader;

    localparam logic [11:0] BASE = 12'h200;
    localparam int          CAP  = 4096 - 512;

    logic        clk;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        mem_en;
    logic        mem_write;
    logic [11:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        error;
    logic [11:0] byte_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected writes: {cycle[31:0], addr[11:0], data[7:0]}.
    logic [51:0] exp_q[$];
    logic [11:0] rd_q[$];
    logic [7:0]  data_q[$];
    logic [51:0] wr_e;
    logic [11:0] rd_e;

    logic [7:0]  mem [0:4095];
    bit          corrupt_en   = 1'b0;
    logic [11:0] corrupt_addr = 12'h202;

    chip8_rom_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .mem_en     (mem_en),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .cpu_halt   (cpu_halt),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model on port A, with an optional stuck value at corrupt_addr.
    initial mem_dout = 8'h00;
    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_write === 1'b1)
            mem[mem_addr] <= (corrupt_en && mem_addr == corrupt_addr) ? 8'h07 : mem_din;
        if (mem_en === 1'b1 && mem_write === 1'b0)
            mem_dout <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe on port A is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (mem_en === 1'b1 && mem_write === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%03h data 0x%02h cycle %0d, expected no write",
                         mem_addr, mem_din, cyc);
            end else begin
                wr_e = exp_q.pop_front();
                if (wr_e !== {cyc[31:0], mem_addr, mem_din}) begin
                    n_fail++;
                    $display("FAIL write_check: got addr 0x%03h data 0x%02h cycle %0d, expected addr 0x%03h data 0x%02h cycle %0d",
                             mem_addr, mem_din, cyc, wr_e[19:8], wr_e[7:0], wr_e[51:20]);
                end
            end
        end
        if (mem_en === 1'b1 && mem_write === 1'b0) begin
            n_checks++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: addr 0x%03h, expected no read", mem_addr);
            end else begin
                rd_e = rd_q.pop_front();
                if (rd_e !== mem_addr) begin
                    n_fail++;
                    $display("FAIL read_check: got addr 0x%03h, expected 0x%03h", mem_addr, rd_e);
                end
            end
        end
    end

    task automatic check_reset_values();
        check("rst_s_ready",    32'(s_ready),    32'd0);
        check("rst_mem_en",     32'(mem_en),     32'd0);
        check("rst_mem_write",  32'(mem_write),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);
        check("rst_cpu_halt",   32'(cpu_halt),   32'd1);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'(BASE));
        check("rst_mem_din",    32'(mem_din),    32'd0);
    endtask

    // Called at a negedge; returns at the negedge after start is sampled.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",       32'(busy),       32'd1);
        check("start_cpu_halt",   32'(cpu_halt),   32'd1);
        check("start_done",       32'(done),       32'd0);
        check("start_error",      32'(error),      32'd0);
        check("start_byte_count", 32'(byte_count), 32'd0);
    endtask

    // Driver: offer one byte for up to budget cycles. Expectations are queued
    // only when the model says the byte should be taken.
    task automatic send_byte(input logic [7:0] d, input bit last, input logic [11:0] addr,
                             input int budget, input bit exp_acc, output bit acc);
        logic [31:0] c;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        acc     = 1'b0;
        for (int k = 0; k < budget && !acc; k++) begin
            if (s_ready) begin
                acc = 1'b1;
                if (exp_acc) begin
                    c = cyc + 1;
                    exp_q.push_back({c, addr, d});
`ifdef CHIP8_LOADER_VERIFY_EN
                    rd_q.push_back(addr);
`endif
                end
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // One full load of data_q[0..n-1]; gap cycles of s_valid=0 before each byte.
    task automatic run_job(input int n, input bit last, input int gap_min, input int gap_max,
                           input bit corrupt);
        int         acc_n;
        logic [7:0] sum_sent;
        logic [7:0] sum_stored;
        logic [11:0] a;
        bit         acc;
        bit         exp_acc;
        bit         ovf;
        bit         exp_err;
        acc_n      = 0;
        sum_sent   = 8'h00;
        sum_stored = 8'h00;
        corrupt_en = corrupt;
        pulse_start();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
            exp_acc = (i < CAP);
            a = BASE + 12'(i);
            send_byte(data_q[i], last && (i == n - 1), a, exp_acc ? 50 : 8, exp_acc, acc);
            check("accept", 32'(acc), 32'(exp_acc));
            if (acc && exp_acc) begin
                acc_n++;
                sum_sent   = sum_sent + data_q[i];
                sum_stored = sum_stored + ((corrupt && a == corrupt_addr) ? 8'h07 : data_q[i]);
            end
            if (!acc) break;
        end
        ovf     = (acc_n == CAP) && !(last && n == CAP);
        exp_err = ovf;
`ifdef CHIP8_LOADER_VERIFY_EN
        exp_err = exp_err || (sum_sent != sum_stored);
`endif
        for (int k = 0; k < 20000 && !done; k++) @(negedge clk);
        check("done",       32'(done),       32'd1);
        check("busy",       32'(busy),       32'd0);
        check("cpu_halt",   32'(cpu_halt),   32'd0);
        check("error",      32'(error),      32'(exp_err));
        check("byte_count", 32'(byte_count), 32'(acc_n));
        check("s_ready",    32'(s_ready),    32'd0);
        check("mem_en",     32'(mem_en),     32'd0);
        // Bytes offered while not loading must never reach memory.
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        check("writes_left", 32'(exp_q.size()), 32'd0);
        check("reads_left",  32'(rd_q.size()),  32'd0);
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
    endtask

    initial begin
        bit acc;
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);

        // Basic three-byte image at full rate.
        data_q = '{8'h12, 8'h34, 8'hAB};
        run_job(3, 1'b1, 0, 0, 1'b0);

        // Valid every third cycle.
        fill_random(2);
        run_job(2, 1'b1, 2, 2, 1'b0);

        // Random lengths and gaps.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(24, 1);
            fill_random(n);
            run_job(n, 1'b1, 0, 3, 1'b0);
        end

        // Overflow: no s_last, one extra byte offered beyond 0xFFF.
        fill_random(CAP + 1);
        run_job(CAP + 1, 1'b0, 0, 0, 1'b0);

        // Image ending exactly at 0xFFF completes cleanly.
        fill_random(CAP);
        run_job(CAP, 1'b1, 0, 0, 1'b0);

`ifdef CHIP8_LOADER_VERIFY_EN
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_job(4, 1'b1, 0, 0, 1'b1);
        run_job(4, 1'b1, 0, 0, 1'b0);
`endif

        // Reset in the middle of a load, then reload.
        fill_random(8);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send_byte(data_q[i], 1'b0, BASE + 12'(i), 50, 1'b1, acc);
            check("midload_accept", 32'(acc), 32'd1);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check_reset_values();
        check("midload_writes_left", 32'(exp_q.size()), 32'd0);
        rd_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fill_random(2);
        run_job(2, 1'b1, 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_rom_loader.md
Name: chip8_rom_loader

Overview:
- Loads a Chip-8 program image from a byte stream (UART/SPI front end) into CPU memory through the memory's read/write port A, starting at BASE_ADDR.
- Holds the CPU in halt while loading and releases it when the load completes.
- Sits directly upstream of the CPU memory, sharing port A with the CPU through an external mux selected by cpu_halt.

Parameters:
- BASE_ADDR, 12'h200: first program address; must be >= 12'h200, below the write-protected charset.
- HOLD_AT_RESET, 1: 1 = cpu_halt is 1 out of reset, so the CPU waits for a load; 0 = cpu_halt is 0 out of reset.

Ports:
- clk  in  1  single clock for the block and memory port A
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse that begins a load
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_last  in  1  marks the final byte of the image
- s_ready  out  1  loader accepts a byte
- mem_en  out  1  to memory a_en
- mem_write  out  1  to memory a_write
- mem_addr  out  12  to memory a_addr
- mem_din  out  8  to memory a_in
- mem_dout  in  8  from memory a_out; valid 1 cycle after mem_en
- cpu_halt  out  1  holds the CPU and gives port A to the loader
- busy  out  1  load or verify in progress
- done  out  1  load finished, sticky until the next start
- error  out  1  overflow or verify mismatch, sticky until the next start
- byte_count  out  12  number of bytes accepted in the current/last load

Behaviour:
- Reset values:
  - state IDLE.
  - s_ready, mem_en, mem_write, busy, done, error = 0.
  - mem_addr = BASE_ADDR; mem_din = 0; byte_count = 0.
  - cpu_halt = HOLD_AT_RESET.
- States: IDLE, LOAD, FLUSH, VERIFY (feature only), DONE.
- IDLE/DONE + start: enter LOAD next cycle.
  - cpu_halt=1, busy=1; done, error, byte_count and the checksum clear.
  - Write pointer set to BASE_ADDR.
- start while busy: ignored.
- LOAD:
  - s_ready=1 combinationally in LOAD.
  - Transfer occurs when s_valid && s_ready.
  - A transfer registers mem_en=1, mem_write=1, mem_addr=pointer, mem_din=s_data for exactly the next cycle (1-cycle write latency, 1 byte/cycle throughput).
  - On each transfer: pointer+1, byte_count+1, checksum += s_data (8-bit wrap).
  - Without a transfer: mem_en=mem_write=0 on the next cycle.
- LOAD exit conditions:
  - Transfer with s_last=1: go to FLUSH.
  - Transfer into address 12'hFFF with s_last=0: error=1, go to FLUSH. The pointer never wraps to 0, and no bytes are accepted afterwards (s_ready=0 outside LOAD).
  - Transfer into 12'hFFF with s_last=1: normal completion, no error.
- FLUSH: one cycle, letting the final write retire. Then go to VERIFY if the feature is enabled, otherwise DONE.
- DONE: busy=0, done=1, cpu_halt=0. mem_en=0, so port A belongs to the CPU.
- s_valid outside LOAD: ignored, never written.
- reset mid-load: immediate return to reset values. Memory already written stays written; the next start reloads from BASE_ADDR.

Optional Feature:
- Macro: CHIP8_LOADER_VERIFY_EN.
- Defined:
  - VERIFY issues mem_en=1, mem_write=0 reads of BASE_ADDR .. BASE_ADDR+byte_count-1, one per cycle.
  - Each mem_dout is summed one cycle after its read issues.
  - After the last read data (read latency +1 cycle), the sum is compared with the load checksum; a mismatch sets error=1.
  - Then DONE; cpu_halt stays 1 until DONE.
  - A load that ended in overflow still verifies the bytes written.
- Undefined: no VERIFY state; FLUSH goes straight to DONE; checksum logic absent. error flags overflow only.

Test Plan:
- Reset with HOLD_AT_RESET=1 -> cpu_halt=1, done=0, s_ready=0, mem_en=0.
- start, stream 3 bytes 8'h12,8'h34,8'hAB (last on 3rd) at full rate -> writes 0x200=12, 0x201=34, 0x202=AB on consecutive cycles, each one cycle after acceptance. byte_count=3, done=1, error=0, cpu_halt=0.
- Stream with s_valid gaps (valid every 3rd cycle), 2 bytes -> no write strobes in gap cycles; addresses 0x200,0x201 only.
- Stream 3584 bytes with s_last=0 throughout -> final write to 0xFFF; s_ready=0 afterwards; error=1, done=1, byte_count=3584, no write to 0x000.
- With CHIP8_LOADER_VERIFY_EN: load 4 bytes 01,02,03,04 with the memory model corrupting 0x202 to 8'h07 -> 4 reads 0x200-0x203 after FLUSH; error=1, done=1. Without corruption -> error=0.
- Assert reset mid-load after 5 bytes, then start and load 2 bytes -> outputs return to reset values immediately; reload writes 0x200,0x201; byte_count=2.
